// File: rtl/mipi_hs_deser_align_if.sv
// Bundle of the HS burst control/data inputs and deserializer outputs
// shared by the MIPI HS deserializer and whatever drives it.
interface mipi_hs_deser_align_if #(
    parameter int WIDTH = 8
);
    logic             HS_DESER_EN;
    logic             DRXHSP;
    logic [WIDTH-1:0] HSRX_DATA;
    logic             HSRX_VALID;
    logic             HSRX_ACTIVE;
    logic             HSRX_SYNC;
    logic             ERR_SOT_HS;
    logic             ERR_SOT_SYNC_HS;

    modport master (
        output HS_DESER_EN,
        output DRXHSP,
        input  HSRX_DATA,
        input  HSRX_VALID,
        input  HSRX_ACTIVE,
        input  HSRX_SYNC,
        input  ERR_SOT_HS,
        input  ERR_SOT_SYNC_HS
    );

    modport slave (
        input  HS_DESER_EN,
        input  DRXHSP,
        output HSRX_DATA,
        output HSRX_VALID,
        output HSRX_ACTIVE,
        output HSRX_SYNC,
        output ERR_SOT_HS,
        output ERR_SOT_SYNC_HS
    );
endinterface

// File: rtl/mipi_hs_deser_align.sv
// MIPI D-PHY HS receive deserializer: hunts for the leader-sequence sync byte
// (optionally tolerating one bit error), then packs the serial stream into WIDTH-bit words.
module mipi_hs_deser_align #(
    parameter int         WIDTH        = 8,
    parameter logic [7:0] SYNC_WORD    = 8'hB8,
    parameter int         HUNT_TIMEOUT = 64,
    parameter int         ERR_TOL      = 1
) (
    input  logic                    RxDDRClkHS,
    input  logic                    RxRstHS,
    mipi_hs_deser_align_if.slave    bus
);

    localparam int BW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_FAIL   = 2'd3;

    localparam logic [7:0]    C_TIMEOUT  = 8'(HUNT_TIMEOUT);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] C_BIT_ONE  = BW'(1);

    function automatic logic [3:0] f_popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [1:0]       r_state;
    logic [7:0]       r_win;
    logic [7:0]       r_hcnt;
    logic [BW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_active;
    logic             r_sync;
    logic             r_sot;
    logic             r_err_sync;

    logic [1:0]       w_state;
    logic [7:0]       w_win;
    logic [7:0]       w_hcnt;
    logic [BW-1:0]    w_bcnt;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_data;
    logic             w_valid;
    logic             w_active;
    logic             w_sync;
    logic             w_sot;
    logic             w_err_sync;

    logic [7:0]       w_shift;
    logic [7:0]       w_hcnt_inc;
    logic [3:0]       w_dist;
    logic             w_exact;
    logic             w_one;
    logic [WIDTH-1:0] w_word_bit;

    // Next-state and next-output computation for the hunt/align FSM.
    always_comb begin
        w_shift    = 8'({bus.DRXHSP, r_win} >> 1);
        w_hcnt_inc = r_hcnt + 8'd1;
        w_dist     = f_popcount8(w_shift ^ SYNC_WORD);
        w_exact    = (w_dist == 4'd0);
        w_one      = (ERR_TOL != 0) && (w_dist == 4'd1);
        w_word_bit = r_word;
        w_word_bit[r_bcnt] = bus.DRXHSP;

        w_state    = r_state;
        w_win      = r_win;
        w_hcnt     = r_hcnt;
        w_bcnt     = r_bcnt;
        w_word     = r_word;
        w_data     = r_data;
        w_valid    = 1'b0;
        w_sync     = 1'b0;
        w_sot      = 1'b0;
        w_err_sync = r_err_sync;

        if (!bus.HS_DESER_EN) begin
            // Burst ended or aborted: drop any partial word and all hunt context.
            w_state    = ST_IDLE;
            w_win      = 8'd0;
            w_hcnt     = 8'd0;
            w_bcnt     = '0;
            w_word     = '0;
            w_err_sync = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The enabling edge already carries hunt bit 1.
                    w_state = ST_HUNT;
                    w_win   = {bus.DRXHSP, 7'b000_0000};
                    w_hcnt  = 8'd1;
                    w_bcnt  = '0;
                    w_word  = '0;
                end
                ST_HUNT: begin
                    w_win  = w_shift;
                    w_hcnt = w_hcnt_inc;
                    if ((w_hcnt_inc >= 8'd8) && (w_exact || w_one)) begin
                        w_state = ST_ACTIVE;
                        w_sync  = 1'b1;
                        w_sot   = !w_exact;
                        w_bcnt  = '0;
                        w_word  = '0;
                    end else if (w_hcnt_inc == C_TIMEOUT) begin
                        w_state    = ST_FAIL;
                        w_err_sync = 1'b1;
                    end else begin
                        w_state = ST_HUNT;
                    end
                end
                ST_ACTIVE: begin
                    w_word = w_word_bit;
                    if (r_bcnt == C_BIT_LAST) begin
                        w_bcnt  = '0;
                        w_data  = w_word_bit;
                        w_valid = 1'b1;
                    end else begin
                        w_bcnt = r_bcnt + C_BIT_ONE;
                    end
                end
                ST_FAIL: begin
                    w_state = ST_FAIL;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end

        w_active = (w_state == ST_ACTIVE);
    end

    // State and registered-output update; reset wins over everything.
    always_ff @(posedge RxDDRClkHS) begin
        if (RxRstHS) begin
            r_state    <= ST_IDLE;
            r_win      <= 8'd0;
            r_hcnt     <= 8'd0;
            r_bcnt     <= '0;
            r_word     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
            r_sync     <= 1'b0;
            r_sot      <= 1'b0;
            r_err_sync <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_win      <= w_win;
            r_hcnt     <= w_hcnt;
            r_bcnt     <= w_bcnt;
            r_word     <= w_word;
            r_data     <= w_data;
            r_valid    <= w_valid;
            r_active   <= w_active;
            r_sync     <= w_sync;
            r_sot      <= w_sot;
            r_err_sync <= w_err_sync;
        end
    end

    assign bus.HSRX_DATA       = r_data;
    assign bus.HSRX_VALID      = r_valid;
    assign bus.HSRX_ACTIVE     = r_active;
    assign bus.HSRX_SYNC       = r_sync;
    assign bus.ERR_SOT_HS      = r_sot;
    assign bus.ERR_SOT_SYNC_HS = r_err_sync;

endmodule

// File: doc/mipi_hs_deser_align.md
MIPI_HS_DESER_ALIGN -- requirements
Module: mipi_hs_deser_align

Interface
REQ-001 Parameter WIDTH, default 8: output word width in bits; legal values 8, 16, 32.
REQ-002 Parameter SYNC_WORD, default 8'hB8: HS leader-sequence (sync) byte, received LSB first.
REQ-003 Parameter HUNT_TIMEOUT, default 64: maximum number of bits sampled in HUNT before sync failure is declared; legal range 8..255.
REQ-004 Parameter ERR_TOL, default 1: 1 accepts a sync byte with one bit in error; 0 accepts exact matches only.
REQ-005 RxDDRClkHS  input  1  RX clock lane clock; all logic on its rising edge; one serial bit sampled per rising edge.
REQ-006 RxRstHS  input  1  reset, synchronous, active-high.
REQ-007 HS_DESER_EN  input  1  high = HS burst in progress; low = idle or abort.
REQ-008 DRXHSP  input  1  serial HS data bit, LSB of each byte first.
REQ-009 HSRX_DATA  output  WIDTH  deserialized word; bit 0 = first bit received.
REQ-010 HSRX_VALID  output  1  one-cycle pulse; HSRX_DATA is new this cycle.
REQ-011 HSRX_ACTIVE  output  1  high while in ACTIVE state.
REQ-012 HSRX_SYNC  output  1  one-cycle pulse on sync byte acceptance.
REQ-013 ERR_SOT_HS  output  1  one-cycle pulse: sync accepted with a single-bit error.
REQ-014 ERR_SOT_SYNC_HS  output  1  level: sync not found within HUNT_TIMEOUT bits; held until HS_DESER_EN falls.

Function
REQ-015 FSM states: IDLE, HUNT, ACTIVE, FAIL; all outputs registered.
REQ-016 IDLE -> HUNT on the first edge with HS_DESER_EN=1; that edge samples DRXHSP as hunt bit 1.
REQ-017 HUNT: 8-bit window shifts right each edge, new bit entering bit 7; window and hunt bit counter clear on HUNT entry.
REQ-018 HUNT: window compared only once at least 8 bits have been sampled; window==SYNC_WORD -> ACTIVE, pulse HSRX_SYNC.
REQ-019 HUNT with ERR_TOL=1: window at Hamming distance exactly 1 from SYNC_WORD -> ACTIVE, pulse HSRX_SYNC and ERR_SOT_HS on the same cycle.
REQ-020 HUNT: hunt bit counter reaching HUNT_TIMEOUT without a match -> FAIL, ERR_SOT_SYNC_HS=1; a match on the HUNT_TIMEOUT-th bit takes precedence over the timeout.
REQ-021 ACTIVE: bit counter (width clog2(WIDTH)) cleared on entry; each edge places DRXHSP at word bit index = counter; counter increments and wraps WIDTH-1 -> 0.
REQ-022 ACTIVE: on the edge sampling word bit WIDTH-1, HSRX_DATA loads the complete word and HSRX_VALID=1 for that cycle; the next edge's bit is bit 0 of the next word with no gap.
REQ-023 Latency: the first data bit is the bit sampled on the edge after the one completing the sync byte; the first HSRX_VALID occurs WIDTH edges after the sync-accept edge.
REQ-024 HSRX_DATA holds its last value when HSRX_VALID=0; never zeroed except by reset.
REQ-025 HS_DESER_EN=0 in any state -> IDLE on that edge; partial word discarded, no HSRX_VALID, counters cleared, ERR_SOT_SYNC_HS cleared.
REQ-026 FAIL: ignore DRXHSP; remain until HS_DESER_EN=0.
REQ-027 HS_DESER_EN re-asserted after a drop starts a fresh HUNT; no state carries over between bursts.
REQ-028 HSRX_SYNC, ERR_SOT_HS and HSRX_VALID are never high at the same time.

Reset
REQ-029 RxRstHS=1 at a rising edge: state IDLE; window, counters and HSRX_DATA = 0; HSRX_VALID, HSRX_ACTIVE, HSRX_SYNC, ERR_SOT_HS, ERR_SOT_SYNC_HS = 0.
REQ-030 Reset overrides HS_DESER_EN and takes effect mid-burst on the same edge; the partial word is lost.
REQ-031 After reset is released, normal operation resumes from the first edge with RxRstHS=0.

Verification
REQ-032 WIDTH=8: EN=1; 0x00 preamble (8 bits), 0xB8, 0x5A, 0xC3 LSB first -> HSRX_SYNC one pulse; HSRX_VALID with 0x5A then 0xC3 exactly 8 edges apart; ERR_SOT_HS=0.
REQ-033 ERR_TOL=1: 0x00 preamble, then 0xB9 (one bit in error), then 0x11 -> HSRX_SYNC and ERR_SOT_HS pulse together; HSRX_DATA=0x11 follows. ERR_TOL=0, same stimulus -> no sync; ERR_SOT_SYNC_HS=1 after 64 hunt bits.
REQ-034 WIDTH=16: 0xB8, then bytes 0x34, 0x12 -> one HSRX_VALID with HSRX_DATA=0x1234, 16 edges after sync accept.
REQ-035 EN dropped after 5 data bits, then a new burst 0xB8, 0xA5 -> no HSRX_VALID for the aborted word; next HSRX_DATA=0xA5.
REQ-036 RxRstHS=1 pulsed mid-word in ACTIVE -> all outputs 0 on that edge; no HSRX_VALID until a new sync is accepted.
REQ-037 HUNT_TIMEOUT=16: only zeros for 20 bits -> ERR_SOT_SYNC_HS=1 on the 16th hunt edge, held; cleared on the edge where EN=0.
